// File: rtl/adpcm_block_reader_pkg.sv
// +--------------------------------------------------------------------+
// | adpcm_block_reader_pkg : shared ADPCM state encodings and constants |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

// Two-phase input event: a level change relative to the delayed copy.
`ifndef ADPCM_TOGGLE
`define ADPCM_TOGGLE(lvl, dly) ((lvl) ^ (dly))
`endif

package adpcm_block_reader_pkg;

    localparam int         HDR_BYTES = 4;
    localparam int         IDX_MAX   = 88;
    localparam logic [7:0] HDR_RSV   = 8'h00;

    function automatic logic [2:0] enc_gray(input logic [2:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reader states; values are enc_gray(0..7) in declaration order.
    typedef enum logic [2:0] {
        ST_H0   = 3'b000,
        ST_H1   = 3'b001,
        ST_H2   = 3'b011,
        ST_H3   = 3'b010,
        ST_DATA = 3'b110,
        ST_LO   = 3'b111,
        ST_HI   = 3'b101,
        ST_SKIP = 3'b100
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adpcm_block_reader.sv
// +--------------------------------------------------------------------+
// | adpcm_block_reader : IMA-ADPCM block stream parser / nibble feeder |
// | Optional header check: define ADPCM_BLOCK_CHECK_EN                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module adpcm_block_reader
    import adpcm_block_reader_pkg::*;
#(
    parameter int BLOCK_BYTES = 256
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               push,
    input  logic [7:0]         rx_byte,
    output logic               full,
    output logic signed [15:0] hdr_pcm,
    output logic signed [7:0]  hdr_idx,
    output logic               hdr_stb,
    output logic               req,
    output logic [3:0]         tx_adpcm,
    input  logic               ack,
    output logic               err,
    output logic [2:0]         cst
);

    localparam int             CW     = $clog2(BLOCK_BYTES);
    localparam logic [CW-1:0]  C_LAST = CW'(BLOCK_BYTES - 1);

    state_t          r_state;
    logic            r_push_d;
    logic            r_guard;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_pcm_lo;
    logic [7:0]      r_pcm_hi;
    logic [7:0]      r_idx;
    logic [3:0]      r_nib_hi;

    logic            w_push_x;
    logic            w_ack_ok;
    logic [CW-1:0]   w_cnt_next;

    assign w_push_x   = `ADPCM_TOGGLE(push, r_push_d);
    // The core still reads idle the cycle after a req toggle.
    assign w_ack_ok   = ack & ~r_guard;
    assign w_cnt_next = (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);

    assign cst  = r_state;
    assign full = (r_state == ST_LO) || (r_state == ST_HI);

`ifdef ADPCM_BLOCK_CHECK_EN
    localparam logic signed [7:0] C_IDX_MAX = 8'(IDX_MAX);

    logic r_err;
    logic w_hdr_bad;

    assign w_hdr_bad = (rx_byte != HDR_RSV) || r_idx[7] || ($signed(r_idx) > C_IDX_MAX);
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_H0;
            r_push_d <= 1'b0;
            r_guard  <= 1'b0;
            r_cnt    <= '0;
            r_pcm_lo <= 8'h00;
            r_pcm_hi <= 8'h00;
            r_idx    <= 8'h00;
            r_nib_hi <= 4'h0;
            hdr_pcm  <= 16'sh0000;
            hdr_idx  <= 8'sh00;
            hdr_stb  <= 1'b0;
            req      <= 1'b0;
            tx_adpcm <= 4'h0;
`ifdef ADPCM_BLOCK_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else if (enable) begin
            r_push_d <= push;
            r_guard  <= 1'b0;
            case (r_state)
                ST_H0: if (w_push_x) begin
                    r_pcm_lo <= rx_byte;
                    r_cnt    <= w_cnt_next;
                    r_state  <= ST_H1;
                end
                ST_H1: if (w_push_x) begin
                    r_pcm_hi <= rx_byte;
                    r_cnt    <= w_cnt_next;
                    r_state  <= ST_H2;
                end
                ST_H2: if (w_push_x) begin
                    r_idx   <= rx_byte;
                    r_cnt   <= w_cnt_next;
                    r_state <= ST_H3;
                end
                // Header fields are staged and published together here.
                ST_H3: if (w_push_x) begin
                    r_cnt <= w_cnt_next;
`ifdef ADPCM_BLOCK_CHECK_EN
                    if (w_hdr_bad) begin
                        r_err   <= 1'b1;
                        r_state <= ST_SKIP;
                    end else begin
                        hdr_pcm <= $signed({r_pcm_hi, r_pcm_lo});
                        hdr_idx <= $signed(r_idx);
                        hdr_stb <= ~hdr_stb;
                        r_state <= ST_DATA;
                    end
`else
                    hdr_pcm <= $signed({r_pcm_hi, r_pcm_lo});
                    hdr_idx <= $signed(r_idx);
                    hdr_stb <= ~hdr_stb;
                    r_state <= ST_DATA;
`endif
                end
                ST_DATA: if (w_push_x) begin
                    r_nib_hi <= rx_byte[7:4];
                    tx_adpcm <= rx_byte[3:0];
                    r_cnt    <= w_cnt_next;
                    r_state  <= ST_LO;
                end
                ST_LO: if (w_ack_ok) begin
                    req      <= ~req;
                    r_guard  <= 1'b1;
                    tx_adpcm <= r_nib_hi;
                    r_state  <= ST_HI;
                end
                // A cleared counter means the byte just issued closed the block.
                ST_HI: if (w_ack_ok) begin
                    req     <= ~req;
                    r_guard <= 1'b1;
                    r_state <= (r_cnt == '0) ? ST_H0 : ST_DATA;
                end
`ifdef ADPCM_BLOCK_CHECK_EN
                ST_SKIP: if (w_push_x) begin
                    r_cnt <= w_cnt_next;
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_H0;
                    end
                end
`endif
                default: r_state <= ST_H0;
            endcase
        end
    end

endmodule

`default_nettype wire
